rr_arbiter_requester_2ch: RTL and testbench
===========================================

Name: rr_arbiter_requester_2ch

Overview:
- Requester-side front end for the 2-request round-robin arbiter. It holds two independent client queues and raises requests[i] while queue i is non-empty.
- It consumes the one-hot grants[1:0] returned by the arbiter and, per grant, pops one entry onto a shared registered output bus tagged with its source.
- It sits between two producer clients and the arbiter plus the shared sink, closing the request/grant loop.

Parameters:
- DATA_W, 8, width of each queued data word.
- DEPTH, 4, entries per channel queue; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  2  per-channel push strobe; bit i pushes to queue i.
- wr_data0  input  DATA_W  push data for channel 0.
- wr_data1  input  DATA_W  push data for channel 1.
- full  output  2  bit i high when queue i holds DEPTH entries.
- requests  output  2  to arbiter; bit i high while queue i is non-empty.
- grants  input  2  from arbiter; one-hot or zero.
- out_valid  output  1  one-cycle pulse when a popped word is presented.
- out_data  output  DATA_W  popped word.
- out_src  output  1  channel index of the popped word.
- err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous assert, released on a clk edge):
  - Both queues empty: count = 0, pointers = 0.
  - requests = 2'b00, full = 2'b00, out_valid = 0, out_data = 0, out_src = 0, err = 0.
  - Reset mid-operation discards all queued data; no out_valid pulse occurs for discarded entries.
- Queues:
  - Per-channel circular buffer with read/write pointers and a count register of width $clog2(DEPTH)+1.
  - Pointers wrap from DEPTH-1 to 0.
  - requests[i] = (count[i] != 0) and full[i] = (count[i] == DEPTH). Both are combinational decodes of the registered count, so there is no combinational path from grants or wr_en to requests.
- Push:
  - On a rising edge with wr_en[i]=1 and full[i]=0, write wr_data_i at wptr[i] and increment wptr[i].
  - If full[i]=1 at that edge, the push is dropped silently. This holds even if a pop on the same channel occurs in the same cycle; there is no pass-through on full.
- Pop (grant honoured):
  - Valid grant = grants is one-hot, and grants[i]=1 while requests[i]=1 at the same edge.
  - On a valid grant, rptr[i] increments. Next cycle: out_valid=1, out_data = entry at the old rptr[i], out_src = i.
  - Latency: grant edge -> output 1 cycle. out_valid is low in every cycle not following a valid grant.
- Simultaneous push and pop on one channel: both occur and count is unchanged (push only if not full, per the rule above).
- Count update per channel: +1 push-only, -1 pop-only, 0 for both or neither.
- Empty: requests[i] drops in the cycle after the edge that pops the last entry. A push into an empty queue raises requests[i] in the cycle after the push edge.
- Back-to-back grants: the arbiter may grant the same channel on consecutive edges. Each valid grant pops exactly one entry, giving consecutive out_valid pulses.
- Protocol errors:
  - grants == 2'b11, or grants[i]=1 while requests[i]=0: no pop on either channel, no out_valid, err set to 1.
  - err is sticky until rst; all other operation continues normally.
- All state updates occur on the rising clk edge.
- The only combinational outputs are requests and full, decoded from registers.

Test Plan:
- Reset: drive rst=1 with random wr_en/grants, then release -> requests=00, full=00, out_valid=0, err=0. Assert rst for 1 cycle while both queues hold 3 entries -> requests=00 after reset, no out_valid.
- Push 0xA1, 0xA2 to ch0; grant 01 on two edges -> out_valid pulses on the two cycles after the grants, with out_data 0xA1 then 0xA2, out_src 0. requests[0] falls after the second pop.
- Fill ch1 with 0x10..0x13 (DEPTH=4) -> full[1]=1. Push 0x14 -> dropped. Grant 10 four times -> data 0x10..0x13 in order, read pointer wraps, fifth grant sets err=1.
- Ch0 holds 2 entries. On one edge push 0x55 to ch0 and grant 01 -> count stays 2, popped word is the oldest, 0x55 emerges after the remaining entry.
- Drive grants=11 with both queues non-empty -> no pop, no out_valid, err=1 and stays 1. Subsequent legal alternating grants 01/10 still pop correctly.
- Alternating grants 01/10 with both queues holding 4 entries -> 8 consecutive out_valid pulses with out_src toggling 0,1,0,1…, then requests=00.

Source files
------------

// File: rtl/rr_arbiter_requester_2ch.sv
// Requester-side front end for a 2-request round-robin arbiter: two client
// queues raise requests, and each granted channel pops one word onto a shared tagged bus.
module rr_arbiter_requester_2ch #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wr_en,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    output logic [1:0]        full,
    output logic [1:0]        requests,
    input  logic [1:0]        grants,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0][DATA_W-1:0] rd_data;
    logic [1:0]             push;
    logic [1:0]             pop;
    logic                   grant_onehot;
    logic                   grant_bad;

    assign wdata = {wr_data1, wr_data0};

    // A grant is honoured only when it is one-hot and aimed at a non-empty queue.
    assign grant_onehot = (grants == 2'b01) || (grants == 2'b10);
    assign grant_bad    = (&grants) || (|(grants & ~requests));

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wptr;
        logic [PTR_W-1:0]  rptr;
        logic [CNT_W-1:0]  count;

        assign requests[i] = (count != '0);
        assign full[i]     = (count == CNT_W'(DEPTH));
        assign push[i]     = wr_en[i] & ~full[i];
        assign pop[i]      = grants[i] & requests[i] & grant_onehot;
        assign rd_data[i]  = mem[rptr];

        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 on overflow.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push[i]) wptr <= wptr + PTR_W'(1);
                if (pop[i])  rptr <= rptr + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        // NOTE: storage is not reset; clearing the count alone makes old entries unreachable.
        always_ff @(posedge clk) begin
            if (push[i]) mem[wptr] <= wdata[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= |pop;
            if (pop[0]) begin
                out_data <= rd_data[0];
                out_src  <= 1'b0;
            end else if (pop[1]) begin
                out_data <= rd_data[1];
                out_src  <= 1'b1;
            end
            if (grant_bad) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_requester_2ch.sv
// Self-checking bench: vector table, directed corner sequences and random
// traffic against a queue-based reference model.
module tb_rr_arbiter_requester_2ch;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        wr_en;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic [1:0]        full;
    logic [1:0]        requests;
    logic [1:0]        grants;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              err;

    rr_arbiter_requester_2ch #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data0(wr_data0), .wr_data1(wr_data1),
        .full(full), .requests(requests), .grants(grants), .out_valid(out_valid),
        .out_data(out_data), .out_src(out_src), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic              m_err;

    typedef struct {
        logic [1:0] we;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] g;
        logic       ov;
        logic [7:0] data;
        logic       src;
        logic [1:0] req;
        logic [1:0] fl;
        logic       er;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic cycle(input logic [1:0] we, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] g);
        int s0, s1;
        logic bad, p0, p1, es;
        logic [7:0] ed;
        wr_en = we; wr_data0 = d0; wr_data1 = d1; grants = g;
        s0 = q0.size(); s1 = q1.size();
        #1;
        check("requests", 32'(requests), 32'({s1 != 0, s0 != 0}));
        check("full", 32'(full), 32'({s1 == DEPTH, s0 == DEPTH}));
        bad = (g == 2'b11) || (g[0] && s0 == 0) || (g[1] && s1 == 0);
        p0 = !bad && g[0];
        p1 = !bad && g[1];
        ed = '0; es = 1'b0;
        if (p0) begin ed = q0.pop_front(); es = 1'b0; end
        if (p1) begin ed = q1.pop_front(); es = 1'b1; end
        if (we[0] && s0 < DEPTH) q0.push_back(d0);
        if (we[1] && s1 < DEPTH) q1.push_back(d1);
        if (bad) m_err = 1'b1;
        @(posedge clk); #1;
        check("out_valid", 32'(out_valid), 32'(p0 | p1));
        if (p0 | p1) begin
            check("out_data", 32'(out_data), 32'(ed));
            check("out_src", 32'(out_src), 32'(es));
        end
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 2'($urandom); grants = 2'($urandom);
        #1;
        check("rst_async_requests", 32'(requests), 32'h0);
        check("rst_async_full", 32'(full), 32'h0);
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_src", 32'(out_src), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        q0.delete(); q1.delete(); m_err = 1'b0;
        wr_en = 2'b00; grants = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_requests", 32'(requests), 32'h0);
        check("post_rst_out_valid", 32'(out_valid), 32'h0);
    endtask

    initial begin
        rst = 1'b1; wr_en = '0; wr_data0 = '0; wr_data1 = '0; grants = '0; m_err = 1'b0;
        vecs[0]  = '{2'b01, 8'hA1, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0};
        vecs[1]  = '{2'b01, 8'hA2, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0};
        vecs[2]  = '{2'b00, 8'h00, 8'h00, 2'b01, 1'b1, 8'hA1, 1'b0, 2'b01, 2'b00, 1'b0};
        vecs[3]  = '{2'b00, 8'h00, 8'h00, 2'b01, 1'b1, 8'hA2, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[4]  = '{2'b10, 8'h00, 8'h10, 2'b00, 1'b0, 8'h00, 1'b0, 2'b10, 2'b00, 1'b0};
        vecs[5]  = '{2'b10, 8'h00, 8'h11, 2'b00, 1'b0, 8'h00, 1'b0, 2'b10, 2'b00, 1'b0};
        vecs[6]  = '{2'b10, 8'h00, 8'h12, 2'b00, 1'b0, 8'h00, 1'b0, 2'b10, 2'b00, 1'b0};
        vecs[7]  = '{2'b10, 8'h00, 8'h13, 2'b00, 1'b0, 8'h00, 1'b0, 2'b10, 2'b10, 1'b0};
        vecs[8]  = '{2'b10, 8'h00, 8'h14, 2'b00, 1'b0, 8'h00, 1'b0, 2'b10, 2'b10, 1'b0};
        vecs[9]  = '{2'b00, 8'h00, 8'h00, 2'b10, 1'b1, 8'h10, 1'b1, 2'b10, 2'b00, 1'b0};
        vecs[10] = '{2'b00, 8'h00, 8'h00, 2'b10, 1'b1, 8'h11, 1'b1, 2'b10, 2'b00, 1'b0};
        vecs[11] = '{2'b00, 8'h00, 8'h00, 2'b10, 1'b1, 8'h12, 1'b1, 2'b10, 2'b00, 1'b0};
        vecs[12] = '{2'b00, 8'h00, 8'h00, 2'b10, 1'b1, 8'h13, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[13] = '{2'b00, 8'h00, 8'h00, 2'b10, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[14] = '{2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b1};

        @(posedge clk); #1;
        do_reset();

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].we, vecs[i].d0, vecs[i].d1, vecs[i].g);
            check($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vecs[i].ov));
            if (vecs[i].ov) begin
                check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
                check($sformatf("vec%0d_src", i), 32'(out_src), 32'(vecs[i].src));
            end
            check($sformatf("vec%0d_req", i), 32'(requests), 32'(vecs[i].req));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].fl));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].er));
        end

        // Simultaneous push and pop on ch0 keeps the count and the order.
        do_reset();
        cycle(2'b01, 8'hB0, 8'h00, 2'b00);
        cycle(2'b01, 8'hB1, 8'h00, 2'b00);
        cycle(2'b01, 8'h55, 8'h00, 2'b01);
        check("pp_oldest", 32'(out_data), 32'hB0);
        cycle(2'b00, 8'h00, 8'h00, 2'b01);
        check("pp_second", 32'(out_data), 32'hB1);
        cycle(2'b00, 8'h00, 8'h00, 2'b01);
        check("pp_pushed", 32'(out_data), 32'h55);
        check("pp_empty", 32'(requests), 32'h0);

        // Push on a full queue is dropped even with a pop in the same cycle.
        for (int k = 0; k < 4; k++) cycle(2'b01, 8'(8'hC0 + k), 8'h00, 2'b00);
        cycle(2'b01, 8'hC4, 8'h00, 2'b01);
        check("fullpp_data", 32'(out_data), 32'hC0);
        for (int k = 1; k < 4; k++) begin
            cycle(2'b00, 8'h00, 8'h00, 2'b01);
            check("fullpp_drain", 32'(out_data), 32'(8'hC0 + k));
        end
        check("fullpp_dropped", 32'(requests), 32'h0);

        // grants == 11 pops nothing and sets the sticky error.
        cycle(2'b11, 8'hD0, 8'hE0, 2'b00);
        cycle(2'b00, 8'h00, 8'h00, 2'b11);
        check("g11_no_valid", 32'(out_valid), 32'h0);
        check("g11_err", 32'(err), 32'h1);
        cycle(2'b00, 8'h00, 8'h00, 2'b01);
        check("g11_after0", 32'({out_src, out_data}), 32'h0D0);
        cycle(2'b00, 8'h00, 8'h00, 2'b10);
        check("g11_after1", 32'({out_src, out_data}), 32'h1E0);
        check("g11_sticky", 32'(err), 32'h1);

        // Alternating grants drain both full queues back to back.
        do_reset();
        for (int k = 0; k < 4; k++) cycle(2'b11, 8'(8'h20 + k), 8'(8'h30 + k), 2'b00);
        for (int k = 0; k < 8; k++) begin
            cycle(2'b00, 8'h00, 8'h00, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("alt_valid", 32'(out_valid), 32'h1);
            check("alt_src", 32'(out_src), 32'(k % 2));
        end
        check("alt_empty", 32'(requests), 32'h0);

        // Reset mid-operation discards queued data.
        for (int k = 0; k < 3; k++) cycle(2'b11, 8'(8'h40 + k), 8'(8'h50 + k), 2'b00);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cycle(2'b00, 8'h00, 8'h00, 2'b00);
            check("midrst_no_valid", 32'(out_valid), 32'h0);
        end

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [1:0] g;
            if (n == 300) do_reset();
            r = $urandom_range(0, 49);
            if (r < 15) g = 2'b00;
            else if (r < 32) g = 2'b01;
            else if (r < 49) g = 2'b10;
            else g = 2'b11;
            cycle(2'($urandom), 8'($urandom), 8'($urandom), g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
